// File: rtl/atree_acc.sv
// atree_acc: accumulates unsigned adder-tree sums over a burst of beats, then
// presents a shifted, saturated result until downstream takes it.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Neither
// ready depends combinationally on the partner's valid. A synchronous clear
// overrides both transfers in the same cycle.
//
// The block alternates between two states:
//   ACC  : in_ready=1, out_valid=0, beats summed into acc
//   HOLD : in_ready=0, out_valid=1, result registers frozen
module atree_acc #(
    parameter int IN_WIDTH  = 10,
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 2,
    parameter int MAX_TERMS = 16,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CW-1:0]        out_count,
    output logic                 out_sat
);

    localparam int AW1 = ACC_WIDTH + 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // running accumulation for the result in progress
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 sat;

    // datapath for the beat currently offered
    logic                 beat_acc;
    logic                 beat_done;
    logic [AW1-1:0]       sum_wide;
    logic                 sum_ovf;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [CW-1:0]        cnt_inc;
    logic [ACC_WIDTH-1:0] shifted;
    logic                 clamp;
    logic [OUT_WIDTH-1:0] res_data;

    assign beat_acc  = in_valid && in_ready && !clear;
    assign cnt_inc   = cnt + CW'(1);
    assign beat_done = beat_acc && (in_last || (cnt_inc == CW'(MAX_TERMS)));

    // Saturating add; the first beat loads rather than adds so a stale acc can
    // never leak into a new result. in_data is zero-extended (unsigned).
    always_comb begin
        sum_wide = AW1'(in_data);
        if (cnt != '0) begin
            sum_wide = {1'b0, acc} + AW1'(in_data);
        end
        sum_ovf = sum_wide[ACC_WIDTH];
        acc_sum = sum_ovf ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
    end

    // Result formatting: shift, then clamp anything that does not fit OUT_WIDTH.
    always_comb begin
        shifted  = acc_sum >> SHIFT;
        clamp    = |(shifted >> OUT_WIDTH);
        res_data = clamp ? {OUT_WIDTH{1'b1}} : OUT_WIDTH'(shifted);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear wins over both handshakes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC: begin
                if (!clear && beat_done) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (clear || out_ready) begin
                    state_nxt = ST_ACC;
                end
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACC:  in_ready  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    // Accumulator, beat counter and sticky saturation for the current result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (clear || (out_valid && out_ready)) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (beat_acc) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            sat <= sat | sum_ovf;
        end
    end

    // Result registers: captured on the final beat, frozen throughout HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (beat_done) begin
            out_data  <= res_data;
            out_count <= cnt_inc;
            out_sat   <= sat | sum_ovf | clamp;
        end
    end

endmodule

// File: tb/tb_atree_acc.sv
// Bench for atree_acc: two instances share all stimulus, one with default
// parameters and one with ACC_WIDTH=10/SHIFT=0 to reach accumulator
// saturation. A queue-based model predicts handshakes and results.
module tb_atree_acc;

    localparam int IW = 10;
    localparam int OW = 8;
    localparam int MT = 16;
    localparam int CW = 5;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          clear;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          out_ready;

    logic          in_ready_a, out_valid_a, out_sat_a;
    logic [OW-1:0] out_data_a;
    logic [CW-1:0] out_count_a;
    logic          in_ready_b, out_valid_b, out_sat_b;
    logic [OW-1:0] out_data_b;
    logic [CW-1:0] out_count_b;

    atree_acc dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a), .out_sat(out_sat_a)
    );

    atree_acc #(.ACC_WIDTH(10), .SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b), .out_sat(out_sat_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // scoreboard: beats of the open result and the pending result (at most one)
    int unsigned   beats_q[$];
    logic [OW-1:0] exp_da_q[$];
    logic [OW-1:0] exp_db_q[$];
    logic          exp_sa_q[$];
    logic          exp_sb_q[$];
    logic [CW-1:0] exp_cnt_q[$];

    function automatic void model_result(input longint unsigned total, input int aw, input int sh,
                                         output logic [OW-1:0] d, output logic s);
        longint unsigned amax;
        longint unsigned acc;
        longint unsigned v;
        amax = (64'd1 << aw) - 1;
        acc  = (total > amax) ? amax : total;
        s    = (total > amax);
        v    = acc >> sh;
        if (v > 255) begin
            d = 8'hFF;
            s = 1'b1;
        end else begin
            d = 8'(v);
        end
    endfunction

    function automatic void close_result();
        longint unsigned total;
        logic [OW-1:0] da, db;
        logic sa, sb;
        total = 0;
        foreach (beats_q[i]) total += beats_q[i];
        model_result(total, 16, 2, da, sa);
        model_result(total, 10, 0, db, sb);
        exp_da_q.push_back(da);
        exp_sa_q.push_back(sa);
        exp_db_q.push_back(db);
        exp_sb_q.push_back(sb);
        exp_cnt_q.push_back(CW'(beats_q.size()));
        beats_q.delete();
    endfunction

    function automatic void drop_pending();
        exp_da_q.delete();
        exp_db_q.delete();
        exp_sa_q.delete();
        exp_sb_q.delete();
        exp_cnt_q.delete();
    endfunction

    function automatic void model_reset();
        beats_q.delete();
        drop_pending();
    endfunction

    task automatic check_outputs();
        bit pend;
        pend = (exp_cnt_q.size() != 0);
        check_eq("in_ready_a", 32'(in_ready_a), 32'(!pend));
        check_eq("out_valid_a", 32'(out_valid_a), 32'(pend));
        check_eq("in_ready_b", 32'(in_ready_b), 32'(!pend));
        check_eq("out_valid_b", 32'(out_valid_b), 32'(pend));
        if (pend) begin
            check_eq("out_data_a", 32'(out_data_a), 32'(exp_da_q[0]));
            check_eq("out_sat_a", 32'(out_sat_a), 32'(exp_sa_q[0]));
            check_eq("out_count_a", 32'(out_count_a), 32'(exp_cnt_q[0]));
            check_eq("out_data_b", 32'(out_data_b), 32'(exp_db_q[0]));
            check_eq("out_sat_b", 32'(out_sat_b), 32'(exp_sb_q[0]));
            check_eq("out_count_b", 32'(out_count_b), 32'(exp_cnt_q[0]));
        end
    endtask

    // driver: one clock cycle; checks state left by previous edges, drives,
    // then predicts the effect of the coming edge
    task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l,
                         input logic ordy, input logic clr);
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        clear     = clr;
        if (clr) begin
            model_reset();
        end else if (exp_cnt_q.size() != 0) begin
            if (ordy) drop_pending();
        end else if (v) begin
            beats_q.push_back(int'(d));
            if (l || beats_q.size() == MT) close_result();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready_a), 1);
        check_eq({tag, "_out_valid"}, 32'(out_valid_a), 0);
        check_eq({tag, "_out_data"}, 32'(out_data_a), 0);
        check_eq({tag, "_out_count"}, 32'(out_count_a), 0);
        check_eq({tag, "_out_sat"}, 32'(out_sat_a), 0);
        check_eq({tag, "_out_valid_b"}, 32'(out_valid_b), 0);
        check_eq({tag, "_out_data_b"}, 32'(out_data_b), 0);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        model_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // look at outputs just after the edge that follows the last driven cycle
    task automatic peek(input string tag, input int d, input int c, input int s);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, 32'(out_valid_a), 1);
        check_eq({tag, "_data"}, 32'(out_data_a), 32'(d));
        check_eq({tag, "_count"}, 32'(out_count_a), 32'(c));
        check_eq({tag, "_sat"}, 32'(out_sat_a), 32'(s));
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // four beats of 153 -> 612 >> 2 = 153
        for (int i = 0; i < 4; i++) cycle(1'b1, 10'd153, 1'(i == 3), 1'b1, 1'b0);
        peek("basic", 153, 4, 0);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // four beats of 1020 -> 4080 >> 2 = 1020, clamped to 255
        for (int i = 0; i < 4; i++) cycle(1'b1, 10'd1020, 1'(i == 3), 1'b1, 1'b0);
        peek("clamp", 255, 4, 1);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // sixteen beats of 1 without in_last; 17th beat waits
        for (int i = 0; i < 16; i++) cycle(1'b1, 10'd1, 1'b0, 1'b0, 1'b0);
        peek("maxterms", 4, 16, 0);
        cycle(1'b1, 10'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 10'd1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 10'd1, 1'b1, 1'b1, 1'b0);
        peek("beat17", 0, 1, 0);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // in_last on the 16th beat gives a single result
        for (int i = 0; i < 16; i++) cycle(1'b1, 10'd2, 1'(i == 15), 1'b1, 1'b0);
        peek("last16", 8, 16, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // backpressure: three stalled cycles, then handoff and a fresh result
        cycle(1'b1, 10'd50, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 10'd50, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 10'd7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 10'd7, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 10'd12, 1'b1, 1'b1, 1'b0);
        peek("fresh", 3, 1, 0);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // reset mid-accumulation discards the partial result
        cycle(1'b1, 10'd100, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 10'd100, 1'b0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 10'd8, 1'b1, 1'b1, 1'b0);
        peek("after_rst", 2, 1, 0);
        check_eq("after_rst_data_b", 32'(out_data_b), 8);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // clear mid-accumulation behaves the same
        cycle(1'b1, 10'd100, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 10'd100, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 10'd8, 1'b1, 1'b1, 1'b0);
        peek("after_clr", 2, 1, 0);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // clear beats a simultaneous beat and a simultaneous output handshake
        cycle(1'b1, 10'd5, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 10'd40, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 10'd40, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // reset while a result is held
        cycle(1'b1, 10'd60, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // narrow accumulator: 1020 + 1020 saturates at 1023
        cycle(1'b1, 10'd1020, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 10'd1020, 1'b1, 1'b1, 1'b0);
        peek("acc_sat", 255, 2, 1);
        check_eq("acc_sat_data_b", 32'(out_data_b), 255);
        check_eq("acc_sat_sat_b", 32'(out_sat_b), 1);
        cycle(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic          v, l, ordy, clr;
            logic [IW-1:0] d;
            v    = ($urandom_range(0, 3) != 0);
            d    = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(900, 1023))
                                               : IW'($urandom_range(0, 1023));
            l    = ($urandom_range(0, 4) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else cycle(v, d, l, ordy, clr);
        end

        @(negedge clk);
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
